camera_emulator: RTL

DVP camera emulator: the transmitting end of the OV7670-style parallel pixel interface consumed by `camera_controller`. It drives `pclk`, `h_ref`, `v_sync` and `data_out` with synthetic QQVGA RGB565 frames, so the capture path, framebuffer and `vga_display` can be exercised in simulation or on the board without a sensor. Its outputs connect directly to the camera-side inputs of the top level in place of the physical camera pins.

---
 rtl/camera_emulator.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/camera_emulator.sv
`default_nettype none
// ============================================================================
//  Module   : camera_emulator
//  Purpose  : Transmitting end of an OV7670-style DVP pixel interface.
//             Generates synthetic RGB565 frames (colour bars, address ramp,
//             checkerboard or a solid colour) two bytes per pixel, with
//             h_ref/v_sync framing, so the capture path can run without a
//             physical sensor.
//  Ports    : clk_25      - system clock, all logic on its rising edge
//             reset       - synchronous, active-high reset
//             enable      - frame generation enable (sampled at frame start)
//             mode        - 0 bars, 1 address ramp, 2 checkerboard, 3 solid
//             solid_color - RGB565 colour used by mode 3
//             pclk        - pixel clock, clk_25 / 2
//             h_ref       - high while valid bytes are on data_out
//             v_sync      - high during the sync lines
//             data_out    - pixel byte (high byte first)
//             frame_done  - one clk_25 pulse at end of frame
//             frame_count - completed frames, wraps 255 -> 0
//  Revision : 1.0 - initial release
// ============================================================================
module camera_emulator #(
  parameter int H_ACTIVE = 160,
  parameter int V_ACTIVE = 120,
  parameter int H_BLANK  = 144,
  parameter int V_SYNC   = 3,
  parameter int V_BACK   = 17,
  parameter int V_FRONT  = 10,
  parameter int BAR_W    = 20
) (
  input  logic        clk_25,
  input  logic        reset,
  input  logic        enable,
  input  logic [1:0]  mode,
  input  logic [15:0] solid_color,
  output logic        pclk,
  output logic        h_ref,
  output logic        v_sync,
  output logic [7:0]  data_out,
  output logic        frame_done,
  output logic [7:0]  frame_count
);

  localparam int LINE_LEN = 2 * H_ACTIVE + H_BLANK;
  localparam int BC_W     = $clog2(LINE_LEN);
  localparam int V_MAX_A  = (V_SYNC > V_BACK) ? V_SYNC : V_BACK;
  localparam int V_MAX_B  = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
  localparam int V_MAX    = (V_MAX_A > V_MAX_B) ? V_MAX_A : V_MAX_B;
  localparam int LN_W     = $clog2(V_MAX + 1);
  localparam int BAR_CW   = $clog2(BAR_W + 1);

  localparam logic [BC_W-1:0]   BC_LAST   = BC_W'(LINE_LEN - 1);
  localparam logic [BC_W:0]     ACT_BYTES = (BC_W + 1)'(2 * H_ACTIVE);
  localparam logic [BAR_CW-1:0] BAR_LAST  = BAR_CW'(BAR_W - 1);
  // Masks selecting x[3] (byte counter bit 4) and y[3]; they truncate to
  // zero when the counters are too narrow to ever reach those values.
  localparam logic [BC_W-1:0]   X3_MASK   = BC_W'(16);
  localparam logic [LN_W-1:0]   Y3_MASK   = LN_W'(8);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VSYNC  = 3'd1,
    ST_VBACK  = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_VFRONT = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic              phase_q, phase_d;
  logic [BC_W-1:0]   bc_q, bc_d;
  logic [LN_W-1:0]   line_q, line_d;
  logic [BAR_CW-1:0] bar_cnt_q, bar_cnt_d;
  logic [2:0]        bar_idx_q, bar_idx_d;
  logic [15:0]       ramp_q, ramp_d;
  logic [1:0]        mode_lat_q, mode_lat_d;
  logic [15:0]       solid_lat_q, solid_lat_d;
  logic [7:0]        frame_count_q, frame_count_d;
  logic              frame_done_q, frame_done_d;
  logic              h_ref_q, h_ref_d;
  logic              v_sync_q, v_sync_d;
  logic [7:0]        data_q, data_d;

  logic              start_frame;
  logic [LN_W-1:0]   line_end;
  logic [15:0]       pixel;

  // All "_d" position values describe the byte slot entered at this tick;
  // the output registers are computed from them so that h_ref, v_sync and
  // data_out change together with the pclk falling edge.
  always_comb begin
    phase_d       = ~phase_q;
    state_d       = state_q;
    bc_d          = bc_q;
    line_d        = line_q;
    bar_cnt_d     = bar_cnt_q;
    bar_idx_d     = bar_idx_q;
    ramp_d        = ramp_q;
    mode_lat_d    = mode_lat_q;
    solid_lat_d   = solid_lat_q;
    frame_count_d = frame_count_q;
    frame_done_d  = 1'b0;
    h_ref_d       = h_ref_q;
    v_sync_d      = v_sync_q;
    data_d        = data_q;
    start_frame   = 1'b0;
    pixel         = 16'h0000;
    line_end      = '0;

    case (state_q)
      ST_VSYNC:  line_end = LN_W'(V_SYNC - 1);
      ST_VBACK:  line_end = LN_W'(V_BACK - 1);
      ST_ACTIVE: line_end = LN_W'(V_ACTIVE - 1);
      ST_VFRONT: line_end = LN_W'(V_FRONT - 1);
      default:   line_end = '0;
    endcase

    if (phase_q) begin
      if (state_q == ST_IDLE) begin
        start_frame = enable;
      end else begin
        // Ramp holds y*H_ACTIVE + x; it steps after the low byte of every
        // active pixel, so after x = H_ACTIVE-1 it already equals the next
        // line's first address.
        if (bc_q[0] && (state_q == ST_ACTIVE) && ({1'b0, bc_q} < ACT_BYTES))
          ramp_d = ramp_q + 16'd1;

        if (bc_q == BC_LAST) begin
          bc_d      = '0;
          bar_cnt_d = '0;
          bar_idx_d = 3'd0;
          if (line_q == line_end) begin
            line_d = '0;
            case (state_q)
              ST_VSYNC:  state_d = ST_VBACK;
              ST_VBACK:  state_d = ST_ACTIVE;
              ST_ACTIVE: state_d = ST_VFRONT;
              default: begin
                frame_done_d  = 1'b1;
                frame_count_d = frame_count_q + 8'd1;
                if (enable) start_frame = 1'b1;
                else        state_d     = ST_IDLE;
              end
            endcase
          end else begin
            line_d = line_q + 1'b1;
          end
        end else begin
          bc_d = bc_q + 1'b1;
          // Leaving a pixel's low byte: advance the bar position.
          if (bc_q[0]) begin
            if (bar_cnt_q == BAR_LAST) begin
              bar_cnt_d = '0;
              if (bar_idx_q != 3'd7) bar_idx_d = bar_idx_q + 3'd1;
            end else begin
              bar_cnt_d = bar_cnt_q + 1'b1;
            end
          end
        end
      end

      if (start_frame) begin
        state_d     = ST_VSYNC;
        bc_d        = '0;
        line_d      = '0;
        bar_cnt_d   = '0;
        bar_idx_d   = 3'd0;
        ramp_d      = 16'h0000;
        mode_lat_d  = mode;
        solid_lat_d = solid_color;
      end

      case (mode_lat_d)
        2'd0:    pixel = {{5{bar_idx_d[2]}}, {6{bar_idx_d[1]}}, {5{bar_idx_d[0]}}};
        2'd1:    pixel = ramp_d;
        2'd2:    pixel = ((|(bc_d & X3_MASK)) ^ (|(line_d & Y3_MASK))) ? 16'hFFFF : 16'h0000;
        default: pixel = solid_lat_d;
      endcase

      h_ref_d  = (state_d == ST_ACTIVE) && ({1'b0, bc_d} < ACT_BYTES);
      v_sync_d = (state_d == ST_VSYNC);
      data_d   = h_ref_d ? (bc_d[0] ? pixel[7:0] : pixel[15:8]) : 8'h00;
    end
  end

  always_ff @(posedge clk_25) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      phase_q       <= 1'b0;
      bc_q          <= '0;
      line_q        <= '0;
      bar_cnt_q     <= '0;
      bar_idx_q     <= 3'd0;
      ramp_q        <= 16'h0000;
      mode_lat_q    <= 2'd0;
      solid_lat_q   <= 16'h0000;
      frame_count_q <= 8'd0;
      frame_done_q  <= 1'b0;
      h_ref_q       <= 1'b0;
      v_sync_q      <= 1'b0;
      data_q        <= 8'h00;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      bc_q          <= bc_d;
      line_q        <= line_d;
      bar_cnt_q     <= bar_cnt_d;
      bar_idx_q     <= bar_idx_d;
      ramp_q        <= ramp_d;
      mode_lat_q    <= mode_lat_d;
      solid_lat_q   <= solid_lat_d;
      frame_count_q <= frame_count_d;
      frame_done_q  <= frame_done_d;
      h_ref_q       <= h_ref_d;
      v_sync_q      <= v_sync_d;
      data_q        <= data_d;
    end
  end

  assign pclk        = phase_q;
  assign h_ref       = h_ref_q;
  assign v_sync      = v_sync_q;
  assign data_out    = data_q;
  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;

endmodule
`default_nettype wire
